// File: rtl/merge2to1_in_router.sv
// Two-input round-robin merge with a single registered output stage.
// The winner is chosen combinationally; grants alternate when both inputs contend.
`ifndef IN_ROUTER_SIZE
`define IN_ROUTER_SIZE 32
`endif

module merge2to1_in_router #(
    parameter int FLIT_W = `IN_ROUTER_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] aIn,
    input  logic              aValid,
    output logic              aReady,
    input  logic [FLIT_W-1:0] bIn,
    input  logic              bValid,
    output logic              bReady,
    output logic [FLIT_W-1:0] dataOut,
    output logic              outValid,
    input  logic              outReady,
    output logic              selOut
);

    logic rrPtr;
    logic load;
    logic aWin;
    logic bWin;
    logic hasWinner;
    logic winSel;

    assign load = !outValid || outReady;

    // rrPtr only breaks ties; a lone valid input always wins
    always_comb begin
        aWin = 1'b0;
        bWin = 1'b0;
        if (aValid && bValid) begin
            if (rrPtr) begin
                bWin = 1'b1;
            end else begin
                aWin = 1'b1;
            end
        end else if (aValid) begin
            aWin = 1'b1;
        end else if (bValid) begin
            bWin = 1'b1;
        end
    end

    assign hasWinner = aWin || bWin;
    assign winSel    = bWin;

    assign aReady = !reset && load && aWin;
    assign bReady = !reset && load && bWin;

    // outReady only reaches the state through load, so outputs stay purely registered
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut  <= '0;
            outValid <= 1'b0;
            selOut   <= 1'b0;
            rrPtr    <= 1'b0;
        end else if (load) begin
            if (hasWinner) begin
                dataOut  <= winSel ? bIn : aIn;
                selOut   <= winSel;
                outValid <= 1'b1;
                rrPtr    <= !winSel;
            end else begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_merge2to1_in_router.sv
// Directed bench for merge2to1_in_router: reset, single input, contention,
// drain, stall and reset-during-stall, one line per transaction.
module tb_merge2to1_in_router;

    logic       clk;
    logic       reset;
    logic [7:0] aIn;
    logic       aValid;
    logic       aReady;
    logic [7:0] bIn;
    logic       bValid;
    logic       bReady;
    logic [7:0] dataOut;
    logic       outValid;
    logic       outReady;
    logic       selOut;

    int checks = 0;
    int errors = 0;

    merge2to1_in_router #(.FLIT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .aIn(aIn),
        .aValid(aValid),
        .aReady(aReady),
        .bIn(bIn),
        .bValid(bValid),
        .bReady(bReady),
        .dataOut(dataOut),
        .outValid(outValid),
        .outReady(outReady),
        .selOut(selOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; aValid = 1'b1; bValid = 1'b1; aIn = 8'hAA; bIn = 8'hBB; outReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (aReady !== 1'b0 || bReady !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready: got a=%b b=%b expected a=0 b=0", aReady, bReady);
            end
            checks++;
            if (outValid !== 1'b0 || dataOut !== 8'h00 || selOut !== 1'b0) begin
                errors++;
                $display("FAIL reset_out: got v=%b d=%h s=%b expected v=0 d=00 s=0", outValid, dataOut, selOut);
            end
            $display("reset cycle %0d: v=%b d=%h s=%b", i, outValid, dataOut, selOut);
        end
    endtask

    task automatic test_single();
        reset = 1'b0; aValid = 1'b1; aIn = 8'h5A; bValid = 1'b0; outReady = 1'b1;
        #1;
        checks++;
        if (aReady !== 1'b1 || bReady !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got a=%b b=%b expected a=1 b=0", aReady, bReady);
        end
        tick();
        aValid = 1'b0;
        checks++;
        if (dataOut !== 8'h5A || selOut !== 1'b0 || outValid !== 1'b1) begin
            errors++;
            $display("FAIL single_out: got d=%h s=%b v=%b expected d=5a s=0 v=1", dataOut, selOut, outValid);
        end
        $display("single: d=%h s=%b v=%b", dataOut, selOut, outValid);
    endtask

    task automatic test_contention();
        logic [7:0] expData [4];
        logic       expSel  [4];
        expData[0] = 8'h11; expData[1] = 8'h22; expData[2] = 8'h11; expData[3] = 8'h22;
        expSel[0]  = 1'b0;  expSel[1]  = 1'b1;  expSel[2]  = 1'b0;  expSel[3]  = 1'b1;
        reset = 1'b1; aValid = 1'b0; bValid = 1'b0;
        tick();
        reset = 1'b0; aValid = 1'b1; bValid = 1'b1; aIn = 8'h11; bIn = 8'h22; outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (aReady !== !expSel[i] || bReady !== expSel[i]) begin
                errors++;
                $display("FAIL contention_ready[%0d]: got a=%b b=%b expected a=%b b=%b",
                         i, aReady, bReady, !expSel[i], expSel[i]);
            end
            tick();
            if (i == 3) begin
                aValid = 1'b0; bValid = 1'b0;
            end
            checks++;
            if (dataOut !== expData[i] || selOut !== expSel[i] || outValid !== 1'b1) begin
                errors++;
                $display("FAIL contention_out[%0d]: got d=%h s=%b v=%b expected d=%h s=%b v=1",
                         i, dataOut, selOut, outValid, expData[i], expSel[i]);
            end
            $display("contention %0d: d=%h s=%b v=%b", i, dataOut, selOut, outValid);
        end
    endtask

    task automatic test_drain();
        outReady = 1'b1; aValid = 1'b0; bValid = 1'b0;
        tick();
        checks++;
        if (outValid !== 1'b0 || dataOut !== 8'h22 || selOut !== 1'b1) begin
            errors++;
            $display("FAIL drain: got v=%b d=%h s=%b expected v=0 d=22 s=1", outValid, dataOut, selOut);
        end
        $display("drain: v=%b d=%h s=%b", outValid, dataOut, selOut);
    endtask

    task automatic test_stall();
        aValid = 1'b1; aIn = 8'h33; bValid = 1'b0; outReady = 1'b1;
        tick();
        aValid = 1'b0; bValid = 1'b1; bIn = 8'h44; outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (aReady !== 1'b0 || bReady !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got a=%b b=%b expected a=0 b=0", i, aReady, bReady);
            end
            tick();
            checks++;
            if (dataOut !== 8'h33 || outValid !== 1'b1 || selOut !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got d=%h v=%b s=%b expected d=33 v=1 s=0",
                         i, dataOut, outValid, selOut);
            end
            $display("stall %0d: d=%h v=%b bReady=%b", i, dataOut, outValid, bReady);
        end
        outReady = 1'b1;
        #1;
        checks++;
        if (bReady !== 1'b1 || aReady !== 1'b0) begin
            errors++;
            $display("FAIL stall_release_ready: got a=%b b=%b expected a=0 b=1", aReady, bReady);
        end
        tick();
        bValid = 1'b0;
        checks++;
        if (dataOut !== 8'h44 || selOut !== 1'b1 || outValid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_out: got d=%h s=%b v=%b expected d=44 s=1 v=1", dataOut, selOut, outValid);
        end
        $display("stall release: d=%h s=%b v=%b", dataOut, selOut, outValid);
    endtask

    task automatic test_reset_stall();
        // Load via A so the round-robin pointer points at B before reset
        aValid = 1'b1; aIn = 8'h66; bValid = 1'b0; outReady = 1'b1;
        tick();
        aValid = 1'b1; bValid = 1'b1; aIn = 8'h77; bIn = 8'h88; outReady = 1'b0;
        tick();
        checks++;
        if (dataOut !== 8'h66 || outValid !== 1'b1) begin
            errors++;
            $display("FAIL rst_stall_pre: got d=%h v=%b expected d=66 v=1", dataOut, outValid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (aReady !== 1'b0 || bReady !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall_ready: got a=%b b=%b expected a=0 b=0", aReady, bReady);
        end
        tick();
        checks++;
        if (outValid !== 1'b0 || dataOut !== 8'h00 || selOut !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall_out: got v=%b d=%h s=%b expected v=0 d=00 s=0", outValid, dataOut, selOut);
        end
        reset = 1'b0; outReady = 1'b1;
        #1;
        checks++;
        if (aReady !== 1'b1 || bReady !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall_grant: got a=%b b=%b expected a=1 b=0", aReady, bReady);
        end
        tick();
        aValid = 1'b0; bValid = 1'b0;
        checks++;
        if (dataOut !== 8'h77 || selOut !== 1'b0 || outValid !== 1'b1) begin
            errors++;
            $display("FAIL rst_stall_first: got d=%h s=%b v=%b expected d=77 s=0 v=1", dataOut, selOut, outValid);
        end
        $display("reset during stall: first grant d=%h s=%b", dataOut, selOut);
    endtask

    initial begin
        reset = 1'b1; aIn = '0; bIn = '0; aValid = 1'b0; bValid = 1'b0; outReady = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_drain();
        test_stall();
        test_reset_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
